div_unit: RTL and testbench

//  Multicycle signed 32-bit divider for the datapath's HI/LO path (MIPS DIV).

---
 rtl/div_unit.sv | 169 ++++++++++++++++
 tb/tb_div_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider for the HI/LO path (MIPS DIV).
//
// Operation: a start with a non-zero divisor latches operand magnitudes and
// signs, runs WIDTH restoring steps (one per cycle), then applies the signs
// and writes quotient -> lo_out, remainder -> hi_out.
// A start with a zero divisor pulses div_zero and leaves the results untouched.
// Timing: start at edge E0, steps on E1..E32, sign fix-up at E33, and
// div_done high in the cycle after E33.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state and outputs
//   div_start  start request, sampled only in IDLE
//   dividend   signed dividend, sampled with div_start
//   divisor    signed divisor, sampled with div_start
//   hi_out     remainder (MIPS HI)
//   lo_out     quotient (MIPS LO)
//   div_busy   high from the accepting edge until the results are written
//   div_done   one-cycle pulse: hi_out/lo_out were just updated
//   div_zero   one-cycle pulse: divisor was zero, nothing was written
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dvsr_q, dvsr_d;    // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  // Restoring-step helpers. A W-bit remainder is enough: |divisor| never
  // exceeds 2^(W-1), so the shifted remainder (< 2*|divisor|) fits in W bits.
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] quo_shift;
  logic             rem_ge;

  always_comb begin
    rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_shift = {quo_q[WIDTH-2:0], 1'b0};
    rem_ge    = (rem_shift >= dvsr_q);
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zero_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_start) begin
          if (divisor == '0) begin
            zero_d = 1'b1;
          end else begin
            // Magnitudes as W-bit unsigned; -2^(W-1) maps onto itself.
            quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_d    = divisor[WIDTH-1]  ? -divisor  : divisor;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (rem_ge) begin
          rem_d = rem_shift - dvsr_q;
          quo_d = quo_shift | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = quo_shift;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // Any start seen here is dropped; IDLE picks it up next cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_busy = busy_q;
  assign div_done = done_q;
  assign div_zero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_busy;
  logic        div_done;
  logic        div_zero;

  int tests;
  int fails;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer division, truncating toward zero, remainder
  // carrying the dividend's sign; the single overflow case is pinned.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge, with the DUT in IDLE.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int n;
    bit seen;
    ref_div(a, b, eq, er);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    chk({tag, " busy"}, 32'(div_busy), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (div_done) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " lo"}, lo_out, eq);
    chk({tag, " hi"}, hi_out, er);
    tick();
    chk({tag, " pulse"}, {30'd0, div_done, div_busy}, 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] ra;
    logic [31:0] rb;

    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    repeat (2) tick();
    chk("rst hi", hi_out, 32'd0);
    chk("rst lo", lo_out, 32'd0);
    chk("rst flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
    reset = 1'b0;
    tick();

    // Signed basics
    run_div(32'd100, 32'd7, "100/7");
    run_div(-32'sd100, 32'd7, "-100/7");
    run_div(32'd100, -32'sd7, "100/-7");
    run_div(-32'sd100, -32'sd7, "-100/-7");

    // Zero divisor after a preload
    run_div(32'd9, 32'd2, "9/2");
    dividend  = 32'd7;
    divisor   = 32'd0;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    chk("zero pulse", {30'd0, div_zero, div_busy}, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) chk("zero single", 32'(div_zero), 32'd0);
      if (div_done || div_busy) seen = 1'b1;
      tick();
    end
    chk("zero no done", 32'(seen), 32'd0);
    chk("zero hi held", hi_out, 32'd1);
    chk("zero lo held", lo_out, 32'd4);

    // Overflow
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "ovf");

    // Second start while busy is ignored
    dividend  = 32'd1000;
    divisor   = 32'd3;
    div_start = 1'b1;
    tick();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      if (n == 9) begin
        div_start = 1'b1;
        dividend  = 32'd5;
        divisor   = 32'd5;
      end else begin
        div_start = 1'b0;
      end
      tick();
      n++;
      if (div_done) seen = 1'b1;
    end
    div_start = 1'b0;
    chk("busy-start latency", 32'(n), 32'd33);
    chk("busy-start lo", lo_out, 32'd333);
    chk("busy-start hi", hi_out, 32'd1);
    tick();

    // Start held through DONE: accepted only on the following IDLE cycle
    dividend  = 32'd20;
    divisor   = 32'd6;
    div_start = 1'b1;
    tick();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (div_done) seen = 1'b1;
    end
    chk("b2b first lo", lo_out, 32'd3);
    tick();
    chk("b2b done ignored", 32'(div_busy), 32'd0);
    tick();
    div_start = 1'b0;
    chk("b2b accepted", 32'(div_busy), 32'd1);
    repeat (34) tick();
    chk("b2b second hi", hi_out, 32'd2);

    // Asynchronous reset mid-operation
    run_div(32'd77, 32'd5, "pre-rst");
    dividend  = 32'd50;
    divisor   = 32'd5;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    #1;
    chk("async rst hi", hi_out, 32'd0);
    chk("async rst lo", lo_out, 32'd0);
    chk("async rst flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (div_done) seen = 1'b1;
    end
    chk("abort no done", 32'(seen), 32'd0);
    run_div(32'd50, 32'd5, "50/5");

    // Random operands
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case (i % 3)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 300);
        default: rb = -$urandom_range(1, 70000);
      endcase
      if (rb == 32'd0) rb = 32'd1;
      run_div(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
